// File: rtl/dac_data_tx_framer.sv
// DAC transmit framer: link training, half-fill FIFO start,
// and midscale output with refill on underrun.
module dac_data_tx_framer #(
  parameter int DAC_DATA_WIDTH = 8,
  parameter int PARALLEL_PATH_NUM = 2,
  parameter int FIFO_DEPTH = 16,
  parameter logic [DAC_DATA_WIDTH-1:0] TRAIN_PATTERN = 8'hA5,
  parameter int TRAIN_LEN = 64
) (
  input  logic clk,
  input  logic rst_n_asyn,
  input  logic tx_en,
  input  logic train_req,
  input  logic [DAC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] s_data_H,
  input  logic [DAC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] s_data_L,
  input  logic s_valid,
  output logic s_ready,
  output logic [DAC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dac_out_H,
  output logic [DAC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] dac_out_L,
  output logic dac_out_vld,
  output logic [1:0] link_state,
  output logic [15:0] underrun_cnt
);

  localparam int W = DAC_DATA_WIDTH * PARALLEL_PATH_NUM;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(TRAIN_LEN + 1);

  localparam logic [DAC_DATA_WIDTH-1:0] MID_S =
    DAC_DATA_WIDTH'(1) << (DAC_DATA_WIDTH - 1);
  localparam logic [W-1:0] MID = {PARALLEL_PATH_NUM{MID_S}};
  localparam logic [W-1:0] TRN = {PARALLEL_PATH_NUM{TRAIN_PATTERN}};
  localparam logic [CW-1:0] HALF = CW'(FIFO_DEPTH / 2);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PLEN = PW'(TRAIN_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0] ucnt;
  logic [2*W-1:0] mem [FIFO_DEPTH];

  logic flush, pop, push, uinc, vld_n;
  logic [W-1:0] h_n, l_n;

  assign s_ready = (state == FILL || state == RUN) && count != FULL;
  assign push = s_valid && s_ready && !flush;
  assign link_state = state;
  assign underrun_cnt = ucnt;

  always_comb begin
    state_n = state;
    phase_n = phase;
    flush = 1'b0;
    pop = 1'b0;
    uinc = 1'b0;
    vld_n = 1'b0;
    h_n = MID;
    l_n = MID;
    if (!tx_en) begin
      state_n = IDLE;
      flush = 1'b1;
    end else if (train_req && (state == FILL || state == RUN)) begin
      state_n = TRAIN;
      flush = 1'b1;
      phase_n = PW'(1);
      h_n = TRN;
      l_n = ~TRN;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = TRAIN;
          flush = 1'b1;
          phase_n = PW'(1);
          h_n = TRN;
          l_n = ~TRN;
        end
        TRAIN: begin
          // phase counts pattern cycles already emitted
          if (phase == PLEN) begin
            state_n = FILL;
          end else begin
            h_n = phase[0] ? ~TRN : TRN;
            l_n = phase[0] ? TRN : ~TRN;
            phase_n = phase + PW'(1);
          end
        end
        FILL: begin
          if (count >= HALF) state_n = RUN;
        end
        RUN: begin
          if (count != '0) begin
            pop = 1'b1;
            vld_n = 1'b1;
            {h_n, l_n} = mem[rd_ptr];
          end else begin
            uinc = 1'b1;
            state_n = FILL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_asyn) begin
    if (!rst_n_asyn) begin
      state <= IDLE;
      phase <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dac_out_H <= MID;
      dac_out_L <= MID;
      dac_out_vld <= 1'b0;
      ucnt <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      dac_out_H <= h_n;
      dac_out_L <= l_n;
      dac_out_vld <= vld_n;
      if (uinc && ucnt != 16'hFFFF) ucnt <= ucnt + 16'd1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop) count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_data_H, s_data_L};
  end

endmodule

// File: tb/tb_dac_data_tx_framer.sv
// Bench for dac_data_tx_framer: directed phases with random
// data, checked against a queue-based transaction model.
module tb_dac_data_tx_framer;

  localparam logic [15:0] PA = 16'hA5A5;
  localparam logic [15:0] PB = 16'h5A5A;
  localparam logic [15:0] MIDW = 16'h8080;

  logic clk = 1'b0;
  logic rst_n_asyn = 1'b0;
  logic tx_en = 1'b0;
  logic train_req = 1'b0;
  logic [15:0] s_data_H = '0;
  logic [15:0] s_data_L = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [15:0] dac_out_H;
  logic [15:0] dac_out_L;
  logic dac_out_vld;
  logic [1:0] link_state;
  logic [15:0] underrun_cnt;

  dac_data_tx_framer dut (
    .clk(clk),
    .rst_n_asyn(rst_n_asyn),
    .tx_en(tx_en),
    .train_req(train_req),
    .s_data_H(s_data_H),
    .s_data_L(s_data_L),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .dac_out_H(dac_out_H),
    .dac_out_L(dac_out_L),
    .dac_out_vld(dac_out_vld),
    .link_state(link_state),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int ms = 0;
  int tcnt = 0;
  logic [31:0] q[$];
  logic [15:0] mh = MIDW;
  logic [15:0] ml = MIDW;
  logic mv = 1'b0;
  logic [15:0] mu = '0;
  logic [31:0] first_push = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    ms = 0;
    tcnt = 0;
    q.delete();
    mh = MIDW;
    ml = MIDW;
    mv = 1'b0;
    mu = '0;
  endtask

  task automatic mstep(input logic tx, input logic tr, input logic v,
                       input logic [15:0] h, input logic [15:0] l);
    logic rdy;
    logic flush;
    rdy = (ms >= 2) && (q.size() != 16);
    flush = 1'b0;
    mh = MIDW;
    ml = MIDW;
    mv = 1'b0;
    if (!tx) begin
      ms = 0;
      flush = 1'b1;
    end else if (tr && ms >= 2) begin
      ms = 1;
      flush = 1'b1;
      tcnt = 1;
      mh = PA;
      ml = PB;
    end else begin
      case (ms)
        0: begin
          ms = 1;
          flush = 1'b1;
          tcnt = 1;
          mh = PA;
          ml = PB;
        end
        1: begin
          if (tcnt == 64) ms = 2;
          else begin
            mh = (tcnt % 2 == 1) ? PB : PA;
            ml = ~mh;
            tcnt++;
          end
        end
        2: if (q.size() >= 8) ms = 3;
        default: begin
          if (q.size() != 0) begin
            {mh, ml} = q.pop_front();
            mv = 1'b1;
          end else begin
            if (mu != 16'hFFFF) mu = mu + 16'd1;
            ms = 2;
          end
        end
      endcase
    end
    if (flush) q.delete();
    else if (v && rdy) q.push_back({h, l});
  endtask

  task automatic cmp_all();
    chk("link_state", 32'(link_state), 32'(ms));
    chk("dac_out_H", 32'(dac_out_H), 32'(mh));
    chk("dac_out_L", 32'(dac_out_L), 32'(ml));
    chk("dac_out_vld", 32'(dac_out_vld), 32'(mv));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(mu));
    chk("s_ready", 32'(s_ready), 32'(ms >= 2 && q.size() != 16));
  endtask

  task automatic cyc(input logic tx, input logic tr, input logic v,
                     input logic [15:0] h, input logic [15:0] l);
    tx_en = tx;
    train_req = tr;
    s_valid = v;
    s_data_H = h;
    s_data_L = l;
    mstep(tx, tr, v, h, l);
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic to_run();
    logic [31:0] d;
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200 && ms != 3; k++) begin
      d = $urandom;
      if (!got && ms >= 2 && q.size() != 16) begin
        first_push = d;
        got = 1'b1;
      end
      cyc(1'b1, 1'b0, ms >= 2, d[31:16], d[15:0]);
    end
    chk("to_run", 32'(link_state), 32'd3);
  endtask

  task automatic stream(input int n);
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      d = $urandom;
      cyc(1'b1, 1'b0, 1'b1, d[31:16], d[15:0]);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && ms != 2; k++)
      cyc(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    mreset();
    @(negedge clk);
    chk("rst_state", 32'(link_state), 32'd0);
    chk("rst_H", 32'(dac_out_H), 32'(MIDW));
    chk("rst_L", 32'(dac_out_L), 32'(MIDW));
    chk("rst_vld", 32'(dac_out_vld), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
    rst_n_asyn = 1'b1;

    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 1'b0, 1'b0, '0, '0);
      if (i == 0) begin
        chk("train0_H", 32'(dac_out_H), 32'(PA));
        chk("train0_L", 32'(dac_out_L), 32'(PB));
      end
      if (i == 63) begin
        chk("train63_state", 32'(link_state), 32'd1);
        chk("train63_H", 32'(dac_out_H), 32'(PB));
      end
    end
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    chk("fill_state", 32'(link_state), 32'd2);
    chk("fill_H", 32'(dac_out_H), 32'(MIDW));
    chk("fill_L", 32'(dac_out_L), 32'(MIDW));
    chk("fill_ready", 32'(s_ready), 32'd1);

    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 16'(i), 16'($urandom));
      if (i == 8) chk("pre_run", 32'(link_state), 32'd2);
      if (i == 9) chk("run_entry", 32'(link_state), 32'd3);
      if (i == 10) begin
        chk("first_word", 32'(dac_out_H), 32'd1);
        chk("first_vld", 32'(dac_out_vld), 32'd1);
      end
    end
    stream(20);

    drain();
    chk("under_state", 32'(link_state), 32'd2);
    chk("under_cnt", 32'(underrun_cnt), 32'd1);
    chk("under_vld", 32'(dac_out_vld), 32'd0);
    chk("under_H", 32'(dac_out_H), 32'(MIDW));

    to_run();
    stream(10);
    for (int k = 0; k < 20 && q.size() > 5; k++)
      cyc(1'b1, 1'b0, 1'b0, '0, '0);
    chk("five_left", 32'(link_state), 32'd3);
    cyc(1'b1, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
    chk("retrain_state", 32'(link_state), 32'd1);
    chk("retrain_H", 32'(dac_out_H), 32'(PA));
    chk("retrain_L", 32'(dac_out_L), 32'(PB));

    to_run();
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    chk("post_flush_word", {dac_out_H, dac_out_L}, first_push);
    stream(6);

    cyc(1'b0, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
    chk("txoff_state", 32'(link_state), 32'd0);
    chk("txoff_H", 32'(dac_out_H), 32'(MIDW));
    chk("txoff_vld", 32'(dac_out_vld), 32'd0);

    to_run();
    stream(4);
    #2 rst_n_asyn = 1'b0;
    #1;
    mreset();
    chk("arst_state", 32'(link_state), 32'd0);
    chk("arst_H", 32'(dac_out_H), 32'(MIDW));
    chk("arst_L", 32'(dac_out_L), 32'(MIDW));
    chk("arst_vld", 32'(dac_out_vld), 32'd0);
    chk("arst_ucnt", 32'(underrun_cnt), 32'd0);
    @(negedge clk);
    rst_n_asyn = 1'b1;

    to_run();
    stream(3);
    force dut.ucnt = 16'hFFFF;
    #1 release dut.ucnt;
    mu = 16'hFFFF;
    drain();
    chk("sat_state", 32'(link_state), 32'd2);
    chk("sat_ucnt", 32'(underrun_cnt), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
